// File: rtl/byte_word_packer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_word_packer_pkg : shared types and helpers for the byte-to-word packer
// Revision: 1.0
// ----------------------------------------------------------------------------
package byte_word_packer_pkg;

  function automatic int pack_word_w(input int bytes_per_word, input int data_width);
    return bytes_per_word * data_width;
  endfunction

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_word_packer_slot_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packer_slot_counter : wrapping byte-slot index with last-slot strobe and clear
// Revision: 1.0
// ----------------------------------------------------------------------------
module packer_slot_counter #(
  parameter int BYTES_PER_WORD = 6,
  parameter int SLOT_W         = $clog2(BYTES_PER_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q;

  assign slot = slot_q;
  assign last = (slot_q == SLOT_W'(BYTES_PER_WORD - 1));

  // Explicit wrap so non-power-of-two word sizes restart at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (clear || (advance && last)) begin
      slot_q <= '0;
    end else if (advance) begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_word_packer : packs LSB-first bytes into words on a valid/ready output
// Revision: 1.0
// ----------------------------------------------------------------------------
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [DATA_WIDTH-1:0]                byte_in,
  input  logic                                 byte_valid_in,
  input  logic                                 flush_in,
  output logic [BYTES_PER_WORD*DATA_WIDTH-1:0] word_out,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]  word_len_out,
  output logic                                 word_valid_out,
  input  logic                                 word_ready_in,
  output logic [$clog2(BYTES_PER_WORD)-1:0]    slot_out,
  output logic                                 overflow_out
);

  localparam int WORD_W = pack_word_w(BYTES_PER_WORD, DATA_WIDTH);
  localparam int SLOT_W = $clog2(BYTES_PER_WORD);
  localparam int LEN_W  = $clog2(BYTES_PER_WORD + 1);

  logic [SLOT_W-1:0] slot;
  logic              last_slot;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic [LEN_W-1:0]  fill_len;
  logic              complete;
  logic              handshake;
  logic              load;
  logic              drop;
  out_state_t        state;
  out_state_t        state_next;
  logic [WORD_W-1:0] word_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovf_q;

  packer_slot_counter #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .SLOT_W         (SLOT_W)
  ) u_slot (
    .clk     (clk_in),
    .rst     (rst_in),
    .advance (byte_valid_in),
    .clear   (flush_in),
    .slot    (slot),
    .last    (last_slot)
  );

  // Assembly contents as they stand once this cycle's byte (if any) is merged.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (byte_valid_in && (slot == SLOT_W'(k))) begin
        asm_next[k*DATA_WIDTH +: DATA_WIDTH] = byte_in;
      end
    end
  end

  assign fill_len  = LEN_W'(slot) + (byte_valid_in ? LEN_W'(1) : LEN_W'(0));
  assign complete  = (byte_valid_in && last_slot) || (flush_in && (fill_len != '0));
  assign handshake = word_valid_out && word_ready_in;
  assign load      = complete && ((state == OUT_EMPTY) || word_ready_in);
  assign drop      = complete && (state == OUT_FULL) && !word_ready_in;

  // Clearing on completion keeps unfilled slots of later flushed words at zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      asm_q <= '0;
    end else if (complete) begin
      asm_q <= '0;
    end else begin
      asm_q <= asm_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      OUT_EMPTY: if (complete) state_next = OUT_FULL;
      OUT_FULL:  if (handshake && !complete) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  always_comb begin
    word_valid_out = (state == OUT_FULL);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_q <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) begin
        word_q <= asm_next;
        len_q  <= fill_len;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign word_out     = word_q;
  assign word_len_out = len_q;
  assign slot_out     = slot;
  assign overflow_out = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_word_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_byte_word_packer : directed and random checks against a queue-based model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_byte_word_packer;

  localparam int BPW = 6;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] byte_d = '0;
  logic          byte_v = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b0;
  logic [BPW*DW-1:0] word;
  logic [2:0]    word_len;
  logic          word_valid;
  logic [2:0]    slot;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes held so far, plus the single output entry.
  byte unsigned      m_q[$];
  logic              m_valid;
  logic [BPW*DW-1:0] m_word;
  int                m_len;
  logic              m_ovf;

  byte_word_packer #(.BYTES_PER_WORD(BPW), .DATA_WIDTH(DW)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .byte_in        (byte_d),
    .byte_valid_in  (byte_v),
    .flush_in       (flush),
    .word_out       (word),
    .word_len_out   (word_len),
    .word_valid_out (word_valid),
    .word_ready_in  (ready),
    .slot_out       (slot),
    .overflow_out   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_word  = '0;
    m_len   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input logic bv, input logic [DW-1:0] b, input logic fl, input logic rd);
    logic hs;
    logic done;
    logic [BPW*DW-1:0] w;
    hs = m_valid && rd;
    if (bv) m_q.push_back(b);
    done = (m_q.size() == BPW) || (fl && m_q.size() > 0);
    if (done) begin
      w = '0;
      foreach (m_q[i]) w = w | ((BPW*DW)'(m_q[i]) << (DW * i));
      if (!m_valid || hs) begin
        m_valid = 1'b1;
        m_word  = w;
        m_len   = m_q.size();
      end else begin
        m_ovf = 1'b1;
      end
      m_q.delete();
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(word_valid), 64'(m_valid));
    chk("slot", 64'(slot), 64'(m_q.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    if (m_valid) begin
      chk("word", 64'(word), 64'(m_word));
      chk("len", 64'(word_len), 64'(m_len));
    end
  endtask

  task automatic step(input logic bv, input logic [DW-1:0] b, input logic fl, input logic rd);
    @(negedge clk);
    byte_v = bv;
    byte_d = b;
    flush  = fl;
    ready  = rd;
    model_edge(bv, b, fl, rd);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    byte_v = 1'b0;
    flush  = 1'b0;
    ready  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_word", 64'(word), 64'h0);
    chk("rst_len", 64'(word_len), 64'h0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Full word, one byte per cycle
    for (int i = 1; i <= BPW; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    chk("dir_full_word", 64'(word), 64'h0000_0605_0403_0201);
    chk("dir_full_len", 64'(word_len), 64'd6);

    // Partial flush, then an empty flush
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("dir_flush_word", 64'(word), 64'h0000_0000_0000_BBAA);
    chk("dir_flush_len", 64'(word_len), 64'd2);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("dir_empty_flush", 64'(word_valid), 64'd0);

    // Byte and flush together
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("dir_bf_word", 64'(word), 64'h0000_0000_0033_2211);
    chk("dir_bf_len", 64'(word_len), 64'd3);

    // Backpressure with overflow
    for (int i = 0; i < BPW; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    chk("dir_ovf", 64'(ovf), 64'd1);
    chk("dir_ovf_hold", 64'(word), 64'h0000_0000_0033_2211);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dir_drain", 64'(word_valid), 64'd0);

    // Back-to-back words
    do_reset();
    for (int i = 0; i < 2 * BPW; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dir_b2b_ovf", 64'(ovf), 64'd0);

    // Mid-word reset
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hE0 + i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < BPW; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    chk("dir_mid_rst_word", 64'(word), 64'h0000_C5C4_C3C2_C1C0);
    chk("dir_mid_rst_ovf", 64'(ovf), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 60);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Downstream consumer of the per-byte event stream in the peripheral FPGA capture path.
- Collects BYTES_PER_WORD consecutive valid bytes into one wide word, LSB-first, and presents the word on a valid/ready interface toward the link/FIFO stage.
- Supports a flush for partial words at end of line or frame.
- Reports dropped words through a sticky overflow flag.

Parameters:
- BYTES_PER_WORD, 6: number of bytes packed per output word; legal range is 2 or more.
- DATA_WIDTH, 8: width of one input byte lane.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- byte_in, input, DATA_WIDTH: input byte, sampled when byte_valid_in=1.
- byte_valid_in, input, 1: one-cycle event qualifying byte_in. There is no input backpressure.
- flush_in, input, 1: closes the current partial word.
- word_out, output, BYTES_PER_WORD*DATA_WIDTH: packed word. Byte k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- word_len_out, output, $clog2(BYTES_PER_WORD+1): number of valid bytes in word_out, range 1..BYTES_PER_WORD.
- word_valid_out, output, 1: word_out and word_len_out are valid.
- word_ready_in, input, 1: downstream accepts the word when valid and ready are both 1.
- slot_out, output, $clog2(BYTES_PER_WORD): index of the next byte slot to be filled.
- overflow_out, output, 1: sticky flag, set when a completed word is dropped.

Behaviour:
- Reset (rst_in=1 at a clock edge) values:
  - slot_out=0, word_valid_out=0, word_out=0, word_len_out=0, overflow_out=0.
  - Assembly register cleared.
  - Reset mid-word discards the partial word, with no output.
- Assembly:
  - On byte_valid_in=1, byte_in is written into assembly slot slot_out.
  - slot_out then increments, wrapping from BYTES_PER_WORD-1 to 0.
- Completion: the word completes when a byte is accepted at slot BYTES_PER_WORD-1, or when flush_in=1 with at least one byte held.
- Flush:
  - A byte and a flush in the same cycle: the byte is included first, then the word closes.
  - Unfilled slots of a flushed word read as zero.
  - The length of a flushed word is the filled count.
  - Flush with zero bytes held is a no-op: no output and no state change.
- Output holding register (one entry): states EMPTY and FULL.
  - EMPTY to FULL when a word completes. word_valid_out rises the cycle after the completing byte or flush; latency is 1 clock.
  - FULL to EMPTY on a handshake (valid and ready) with no new completion that cycle.
  - FULL to FULL on a handshake plus a completion in the same cycle. The new word loads with no bubble.
  - FULL with no handshake plus a completion: the new word is dropped. overflow_out is set and held until reset. The holding register keeps the old word. The assembly register and slot_out restart at 0 as normal.
- Stability: while word_valid_out=1 and word_ready_in=0, word_out and word_len_out must not change.
- Assembly is independent of the output state. Bytes keep being accepted while FULL.
- Throughput: one byte per cycle sustained. Words are produced at most once every BYTES_PER_WORD cycles unless flushes intervene.
- Widths: word_len_out holds BYTES_PER_WORD without truncation. slot_out wraps explicitly and does not rely on power-of-two rollover.

Decomposition:
- Shared package contains:
  - localparam PACK_WORD_W = BYTES_PER_WORD*DATA_WIDTH, or a function computing it.
  - An enum out_state_t {OUT_EMPTY, OUT_FULL}.
- One sub-module, packer_slot_counter: wrapping slot counter with a "last slot" strobe and a synchronous clear for flush.
- Top level holds:
  - the assembly register,
  - the holding register and FSM,
  - the overflow logic.

Test Plan:
- Six bytes, word_ready_in=1, BYTES_PER_WORD=6, one byte per cycle: bytes 01,02,03,04,05,06 -> next cycle word_valid_out=1, word_out=48'h060504030201, word_len_out=6, slot_out=0.
- Partial flush: bytes AA,BB, then flush_in alone -> word_out=48'h00000000BBAA, len=2. A second flush with no bytes -> no valid.
- Byte and flush in the same cycle: bytes 11,22, then 33 with flush_in=1 -> word=...332211, len=3, valid the next cycle.
- Backpressure:
  - word_ready_in=0 while the first word is held: word_out stays stable.
  - Six more bytes arrive -> overflow_out=1, and the first word is still presented.
  - Raise ready -> the first word is accepted, then valid drops.
- Back-to-back: 12 consecutive bytes with ready=1 -> two words, each valid for exactly one cycle, with no bubble and no overflow.
- Mid-word reset: 3 bytes, rst_in for 1 cycle, then 6 bytes -> only one word is emitted and it contains only the post-reset bytes; overflow_out=0.
